multicycle_control_unit: RTL and testbench

- Multi-cycle control FSM for the KGP-miniRISC core.
- Sits directly upstream of data_path.
  - Consumes the data path's decoded opcode_out/func_out.
  - Drives every data_path control input, sequenced per instruction class.
- Replaces the hand-driven control stimulus used during data path bring-up.
- Adds PC/IR enables, an illegal-instruction trap and a retired-instruction counter.

---
 rtl/multicycle_control_unit.sv | 82 ++++++++
 tb/tb_multicycle_control_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle control FSM sequencing data_path per instruction class
module multicycle_control_unit #(
  parameter int CNT_W = 32,
  parameter logic [5:0] HALT_OPC = 6'b111111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode_in,
  input  logic [5:0]       func_in,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       reg_write,
  output logic             imm_mux_ctrl,
  output logic             alu_mux_ctrl,
  output logic [3:0]       alu_op,
  output logic             dmem_enable,
  output logic             dmem_write_enable,
  output logic [1:0]       reg_write_mux_ctrl,
  output logic [4:0]       br_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  state_t state, nxt;
  logic [5:0] opc, fn;
  logic in_br, in_ok, is_r, is_ai, is_lw, is_sw, is_br, is_link, ex, mm, wb, act;
  assign in_br = opcode_in[5:3] == 3'b001 && opcode_in[2:0] != 3'b111;
  assign in_ok = (opcode_in == 6'd0 && func_in <= 6'd10) || opcode_in inside {6'd1, 6'd2, 6'd3, 6'd4} || in_br;
  assign is_r = opc == 6'd0;
  assign is_ai = opc == 6'd1 || opc == 6'd2;
  assign is_lw = opc == 6'd3;
  assign is_sw = opc == 6'd4;
  assign is_br = opc[5:3] == 3'b001 && opc[2:0] != 3'b111;
  assign is_link = opc == 6'b001100;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      opc <= '0;
      fn <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE) begin
        opc <= opcode_in;
        fn <= func_in;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  nxt = DECODE;
      DECODE: nxt = opcode_in == HALT_OPC ? HALT : in_ok ? EXEC : TRAP;
      EXEC:   nxt = is_br ? FETCH : (is_lw || is_sw) ? MEM : WB;
      MEM:    nxt = is_lw ? WB : FETCH;
      WB:     nxt = FETCH;
      default: nxt = state;
    endcase
  end
  always_comb begin
    ex = state == EXEC;
    mm = state == MEM;
    wb = state == WB;
    act = ex || mm || wb;
    ir_en = state == FETCH;
    halted = state == HALT;
    illegal = state == TRAP;
    pc_en = wb || (mm && is_sw) || (ex && is_br);
    alu_op = act && is_r ? fn[3:0] : act && opc == 6'd2 ? 4'd1 : 4'd0;
    imm_mux_ctrl = act && (is_ai || is_lw);
    alu_mux_ctrl = act && (is_ai || is_lw);
    reg_write = (wb && (is_r || is_ai)) || (ex && is_link) ? 2'b01 : wb && is_lw ? 2'b10 : 2'b00;
    reg_write_mux_ctrl = wb && (is_r || is_ai) ? 2'b10 : wb && is_lw ? 2'b01 : 2'b00;
    dmem_enable = ((mm || wb) && is_lw) || (mm && is_sw);
    dmem_write_enable = mm && is_sw;
    br_op = ex && is_br ? {1'b1, opc[3:0]} : 5'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) retired <= '0;
    else if (pc_en) retired <= retired + CNT_W'(1);
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
  logic clk = 0, rst = 1;
  logic [5:0] opcode_in = 0, func_in = 0;
  logic ir_en, pc_en, imm_mux_ctrl, alu_mux_ctrl, dmem_enable, dmem_write_enable, halted, illegal;
  logic [1:0] reg_write, reg_write_mux_ctrl;
  logic [3:0] alu_op;
  logic [4:0] br_op;
  logic [31:0] retired;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [20:0] v; logic [31:0] r; string nm;} exp_t;
  exp_t q[$];

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode_in(opcode_in), .func_in(func_in),
    .ir_en(ir_en), .pc_en(pc_en), .reg_write(reg_write), .imm_mux_ctrl(imm_mux_ctrl),
    .alu_mux_ctrl(alu_mux_ctrl), .alu_op(alu_op), .dmem_enable(dmem_enable),
    .dmem_write_enable(dmem_write_enable), .reg_write_mux_ctrl(reg_write_mux_ctrl),
    .br_op(br_op), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] v(input logic ir, pc, input logic [1:0] rw, input logic imm, am,
      input logic [3:0] aop, input logic de, dwe, input logic [1:0] rwm, input logic [4:0] br,
      input logic h, il);
    return {ir, pc, rw, imm, am, aop, de, dwe, rwm, br, h, il};
  endfunction

  localparam logic [20:0] F = 21'h100000, Z = 21'h0;

  // Set inputs for the current cycle, queue the outputs expected during it, then advance.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
      input logic [20:0] e, input logic [31:0] ret, input string nm);
    rst = r;
    opcode_in = o;
    func_in = f;
    q.push_back('{e, ret, nm});
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [20:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {ir_en, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op, dmem_enable,
               dmem_write_enable, reg_write_mux_ctrl, br_op, halted, illegal};
        n_chk++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s ctrl: got %b expected %b", e.nm, act, e.v);
        end
        n_chk++;
        if (retired !== e.r) begin
          n_fail++;
          $display("FAIL %s retired: got %0d expected %0d", e.nm, retired, e.r);
        end
      end
    end
  end

  initial begin
    logic [20:0] xe, xw;
    int ret;
    repeat (2) @(posedge clk);
    #1;
    xe = v(0,0,2'b00,0,0,4'd3,0,0,2'b00,5'd0,0,0);
    xw = v(0,1,2'b01,0,0,4'd3,0,0,2'b10,5'd0,0,0);
    ret = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 6'd0, 6'd3, F, ret, "xor_fetch");
      cyc(0, 6'd0, 6'd3, Z, ret, "xor_decode");
      cyc(0, 6'd0, 6'd3, xe, ret, "xor_exec");
      cyc(0, 6'd0, 6'd3, xw, ret, "xor_wb");
      ret++;
    end
    cyc(0, 6'd3, 6'd0, F, 4, "lw_fetch");
    cyc(0, 6'd3, 6'd0, Z, 4, "lw_decode");
    cyc(0, 6'd3, 6'd0, v(0,0,2'b00,1,1,4'd0,0,0,2'b00,5'd0,0,0), 4, "lw_exec");
    cyc(0, 6'd3, 6'd0, v(0,0,2'b00,1,1,4'd0,1,0,2'b00,5'd0,0,0), 4, "lw_mem");
    cyc(0, 6'd3, 6'd0, v(0,1,2'b10,1,1,4'd0,1,0,2'b01,5'd0,0,0), 4, "lw_wb");
    cyc(0, 6'd4, 6'd0, F, 5, "sw_fetch");
    cyc(0, 6'd4, 6'd0, Z, 5, "sw_decode");
    cyc(0, 6'd4, 6'd0, Z, 5, "sw_exec");
    cyc(0, 6'd4, 6'd0, v(0,1,2'b00,0,0,4'd0,1,1,2'b00,5'd0,0,0), 5, "sw_mem");
    cyc(0, 6'd1, 6'd7, F, 6, "addi_fetch");
    cyc(0, 6'd1, 6'd7, Z, 6, "addi_decode");
    cyc(0, 6'd1, 6'd7, v(0,0,2'b00,1,1,4'd0,0,0,2'b00,5'd0,0,0), 6, "addi_exec");
    cyc(0, 6'd1, 6'd7, v(0,1,2'b01,1,1,4'd0,0,0,2'b10,5'd0,0,0), 6, "addi_wb");
    cyc(0, 6'd2, 6'd0, F, 7, "compi_fetch");
    cyc(0, 6'd2, 6'd0, Z, 7, "compi_decode");
    cyc(0, 6'd2, 6'd0, v(0,0,2'b00,1,1,4'd1,0,0,2'b00,5'd0,0,0), 7, "compi_exec");
    cyc(0, 6'd2, 6'd0, v(0,1,2'b01,1,1,4'd1,0,0,2'b10,5'd0,0,0), 7, "compi_wb");
    cyc(0, 6'b001010, 6'd0, F, 8, "br_fetch");
    cyc(0, 6'b001010, 6'd0, Z, 8, "br_decode");
    cyc(0, 6'b001010, 6'd0, v(0,1,2'b00,0,0,4'd0,0,0,2'b00,5'b11010,0,0), 8, "br_exec");
    cyc(0, 6'b001100, 6'd0, F, 9, "link_fetch");
    cyc(0, 6'b001100, 6'd0, Z, 9, "link_decode");
    cyc(0, 6'b001100, 6'd0, v(0,1,2'b01,0,0,4'd0,0,0,2'b00,5'b11100,0,0), 9, "link_exec");
    cyc(0, 6'd0, 6'd10, F, 10, "r10_fetch");
    cyc(0, 6'd0, 6'd10, Z, 10, "r10_decode");
    cyc(0, 6'd0, 6'd10, v(0,0,2'b00,0,0,4'd10,0,0,2'b00,5'd0,0,0), 10, "r10_exec");
    cyc(0, 6'd0, 6'd10, v(0,1,2'b01,0,0,4'd10,0,0,2'b10,5'd0,0,0), 10, "r10_wb");
    cyc(0, 6'd3, 6'd0, F, 11, "rlw_fetch");
    cyc(0, 6'd3, 6'd0, Z, 11, "rlw_decode");
    cyc(0, 6'd3, 6'd0, v(0,0,2'b00,1,1,4'd0,0,0,2'b00,5'd0,0,0), 11, "rlw_exec");
    cyc(1, 6'd3, 6'd0, v(0,0,2'b00,1,1,4'd0,1,0,2'b00,5'd0,0,0), 11, "rlw_mem");
    cyc(0, 6'd0, 6'd11, F, 0, "post_rst_fetch");
    cyc(0, 6'd0, 6'd11, Z, 0, "r11_decode");
    for (int i = 0; i < 10; i++) cyc(0, 6'd0, 6'd11, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,0,1), 0, "r11_trap");
    cyc(1, 6'd0, 6'd0, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,0,1), 0, "trap_rst");
    cyc(0, 6'd1, 6'd0, F, 0, "addi2_fetch");
    cyc(0, 6'd1, 6'd0, Z, 0, "addi2_decode");
    cyc(0, 6'd1, 6'd0, v(0,0,2'b00,1,1,4'd0,0,0,2'b00,5'd0,0,0), 0, "addi2_exec");
    cyc(0, 6'd1, 6'd0, v(0,1,2'b01,1,1,4'd0,0,0,2'b10,5'd0,0,0), 0, "addi2_wb");
    cyc(0, 6'b010101, 6'd0, F, 1, "ill_fetch");
    cyc(0, 6'b010101, 6'd0, Z, 1, "ill_decode");
    for (int i = 0; i < 10; i++) cyc(0, 6'd3, 6'd0, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,0,1), 1, "ill_trap");
    cyc(1, 6'd0, 6'd0, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,0,1), 1, "ill_rst");
    cyc(0, 6'b001111, 6'd0, F, 0, "br15_fetch");
    cyc(0, 6'b001111, 6'd0, Z, 0, "br15_decode");
    cyc(0, 6'b001111, 6'd0, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,0,1), 0, "br15_trap");
    cyc(1, 6'd0, 6'd0, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,0,1), 0, "br15_rst");
    cyc(0, 6'b111111, 6'd0, F, 0, "halt_fetch");
    cyc(0, 6'b111111, 6'd0, Z, 0, "halt_decode");
    for (int i = 0; i < 10; i++) cyc(0, 6'd0, 6'd3, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,1,0), 0, "halted");
    cyc(1, 6'd0, 6'd0, v(0,0,2'b00,0,0,4'd0,0,0,2'b00,5'd0,1,0), 0, "halt_rst");
    cyc(0, 6'd0, 6'd0, F, 0, "final_fetch");
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
